// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared gate/source encodings and flit kinds for the router
package noc_pkg;

  localparam int NUM_GATES = 5;

  localparam logic [2:0] GATE_N  = 3'd0;
  localparam logic [2:0] GATE_E  = 3'd1;
  localparam logic [2:0] GATE_S  = 3'd2;
  localparam logic [2:0] GATE_W  = 3'd3;
  localparam logic [2:0] GATE_IP = 3'd4;

  // Owner value meaning "nobody holds this gate"; never a legal source ID.
  localparam logic [3:0] SRC_FREE = 4'hF;

  typedef enum logic [1:0] {
    KIND_HEAD = 2'b00,
    KIND_BODY = 2'b01,
    KIND_TAIL = 2'b10,
    KIND_RSVD = 2'b11
  } flit_kind_e;

endpackage

// File: rtl/gate_owner_slot.sv
// rtl/gate_owner_slot.sv - one output gate: owner register, idle counter, watchdog
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   i_claim        accepted, legal claim addressed to this gate this cycle
//   i_source       requesting source ID (never SRC_FREE when i_claim is set)
//   i_kind         flit kind of the claim (never KIND_RSVD when i_claim is set)
//   o_owner        registered current owner, SRC_FREE when free
//   o_timeout      registered one-cycle pulse after a watchdog release
//   o_err          combinational: this claim is inconsistent with the owner
module gate_owner_slot
  import noc_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_claim,
  input  logic [3:0] i_source,
  input  flit_kind_e i_kind,
  output logic [3:0] o_owner,
  output logic       o_timeout,
  output logic       o_err
);

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  logic [3:0]       r_owner;
  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  logic w_owned;
  logic w_mine;
  logic w_acquire;
  logic w_expire;

  assign w_owned   = (r_owner != SRC_FREE);
  // Source is never SRC_FREE on a claim, so a match also implies owned.
  assign w_mine    = i_claim && (i_source == r_owner);
  assign w_acquire = i_claim && (i_kind == KIND_HEAD) && !w_owned;
  assign w_expire  = (TIMEOUT != 0) && w_owned && (r_cnt == TO_VAL);

  always_comb begin
    o_err = 1'b0;
    if (i_claim) begin
      case (i_kind)
        KIND_HEAD: o_err = w_owned && !w_mine;
        KIND_BODY: o_err = !w_mine;
        KIND_TAIL: o_err = !w_mine;
        default:   o_err = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_owner   <= SRC_FREE;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      // Owner activity beats the watchdog even in the expiry cycle.
      if (w_mine) begin
        r_cnt <= '0;
        if (i_kind == KIND_TAIL) begin
          r_owner <= SRC_FREE;
        end
      end else if (w_acquire) begin
        r_owner <= i_source;
        r_cnt   <= '0;
      end else if (w_expire) begin
        r_owner   <= SRC_FREE;
        r_cnt     <= '0;
        r_timeout <= 1'b1;
      end else if (w_owned && (TIMEOUT != 0)) begin
        // Stops at TO_VAL because reaching it forces a release next edge.
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_owner   = r_owner;
  assign o_timeout = r_timeout;

endmodule

// File: rtl/gate_owner_table.sv
// rtl/gate_owner_table.sv - per-router ownership table for the five output gates
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   claim_valid/source/gate/kind       flit claim presented this cycle
//   grant_in                           comparator grant for that claim
//   north/east/south/west/ip_source    registered owner per gate, 4'hF when free
//   busy                               bit g set while gate g is owned
//   timeout_pulse                      one-cycle pulse per watchdog-released gate
//   err_pulse                          one-cycle pulse on illegal/inconsistent claim
module gate_owner_table
  import noc_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       claim_valid,
  input  logic [3:0] claim_source,
  input  logic [2:0] claim_gate,
  input  logic [1:0] claim_kind,
  input  logic       grant_in,
  output logic [3:0] north_source,
  output logic [3:0] east_source,
  output logic [3:0] south_source,
  output logic [3:0] west_source,
  output logic [3:0] ip_source,
  output logic [4:0] busy,
  output logic [4:0] timeout_pulse,
  output logic       err_pulse
);

  // A disabled watchdog would give a zero-width counter; keep one bit.
  localparam int CW = (CNT_W < 1) ? 1 : CNT_W;

  logic                 w_legal;
  logic                 w_illegal;
  logic                 w_accept;
  flit_kind_e           w_kind;
  logic [NUM_GATES-1:0] w_claim;
  logic [NUM_GATES-1:0] w_slot_err;
  logic [3:0]           w_owner [NUM_GATES];
  logic                 r_err;

  assign w_kind    = flit_kind_e'(claim_kind);
  assign w_legal   = (claim_gate <= GATE_IP) && (claim_source != SRC_FREE) &&
                     (w_kind != KIND_RSVD);
  // Illegal claims are flagged whether or not the comparator granted them.
  assign w_illegal = claim_valid && !w_legal;
  assign w_accept  = claim_valid && grant_in && w_legal;

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_slot
    assign w_claim[g] = w_accept && (claim_gate == 3'(g));
    assign busy[g]    = (w_owner[g] != SRC_FREE);

    gate_owner_slot #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CW)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_claim   (w_claim[g]),
      .i_source  (claim_source),
      .i_kind    (w_kind),
      .o_owner   (w_owner[g]),
      .o_timeout (timeout_pulse[g]),
      .o_err     (w_slot_err[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_illegal || (|w_slot_err);
    end
  end

  assign north_source = w_owner[GATE_N];
  assign east_source  = w_owner[GATE_E];
  assign south_source = w_owner[GATE_S];
  assign west_source  = w_owner[GATE_W];
  assign ip_source    = w_owner[GATE_IP];
  assign err_pulse    = r_err;

endmodule

// File: tb/tb_gate_owner_table.sv
// tb/tb_gate_owner_table.sv - self-checking bench for gate_owner_table
module tb_gate_owner_table;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       claim_valid = 1'b0;
  logic [3:0] claim_source = 4'h0;
  logic [2:0] claim_gate = 3'd0;
  logic [1:0] claim_kind = 2'b00;
  logic       grant_in = 1'b0;
  logic [3:0] north_source, east_source, south_source, west_source, ip_source;
  logic [4:0] busy, timeout_pulse;
  logic       err_pulse;

  gate_owner_table #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .claim_valid   (claim_valid),
    .claim_source  (claim_source),
    .claim_gate    (claim_gate),
    .claim_kind    (claim_kind),
    .grant_in      (grant_in),
    .north_source  (north_source),
    .east_source   (east_source),
    .south_source  (south_source),
    .west_source   (west_source),
    .ip_source     (ip_source),
    .busy          (busy),
    .timeout_pulse (timeout_pulse),
    .err_pulse     (err_pulse)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference: who owns each gate, and the edge number of the owner's last
  // head/body.  A gate whose owner has been silent for more than TO edges
  // is released on that edge.
  logic [3:0] m_owner [5];
  int         m_last  [5];
  logic [4:0] m_to;
  logic       m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_step(input logic rst, input logic v, input logic [3:0] src,
                            input logic [2:0] gate, input logic [1:0] kind, input logic gr);
    bit touched [5];
    bit legal;
    bit mine;
    int g;
    m_to  = 5'b0;
    m_err = 1'b0;
    for (int i = 0; i < 5; i++) touched[i] = 1'b0;
    if (!rst) begin
      for (int i = 0; i < 5; i++) m_owner[i] = 4'hF;
    end else begin
      legal = (gate <= 3'd4) && (src != 4'hF) && (kind != 2'b11);
      if (v && !legal) m_err = 1'b1;
      if (v && gr && legal) begin
        g    = int'(gate);
        mine = (m_owner[g] == src);
        if (kind == 2'b00) begin
          if (m_owner[g] == 4'hF) begin
            m_owner[g] = src; m_last[g] = cyc; touched[g] = 1'b1;
          end else if (mine) begin
            m_last[g] = cyc; touched[g] = 1'b1;
          end else m_err = 1'b1;
        end else if (kind == 2'b01) begin
          if (mine) begin m_last[g] = cyc; touched[g] = 1'b1; end
          else m_err = 1'b1;
        end else begin
          if (mine) begin m_owner[g] = 4'hF; touched[g] = 1'b1; end
          else m_err = 1'b1;
        end
      end
      for (int i = 0; i < 5; i++) begin
        if (!touched[i] && m_owner[i] != 4'hF && (cyc - m_last[i]) > TO) begin
          m_owner[i] = 4'hF;
          m_to[i]    = 1'b1;
        end
      end
    end
  endtask

  task automatic do_cycle(input logic rst, input logic v, input logic [3:0] src,
                          input logic [2:0] gate, input logic [1:0] kind, input logic gr);
    logic [4:0] exp_busy;
    rst_n = rst; claim_valid = v; claim_source = src;
    claim_gate = gate; claim_kind = kind; grant_in = gr;
    @(posedge clk);
    cyc++;
    model_step(rst, v, src, gate, kind, gr);
    #1;
    for (int i = 0; i < 5; i++) exp_busy[i] = (m_owner[i] != 4'hF);
    check("north_source",  32'(north_source),  32'(m_owner[0]));
    check("east_source",   32'(east_source),   32'(m_owner[1]));
    check("south_source",  32'(south_source),  32'(m_owner[2]));
    check("west_source",   32'(west_source),   32'(m_owner[3]));
    check("ip_source",     32'(ip_source),     32'(m_owner[4]));
    check("busy",          32'(busy),          32'(exp_busy));
    check("timeout_pulse", 32'(timeout_pulse), 32'(m_to));
    check("err_pulse",     32'(err_pulse),     32'(m_err));
  endtask

  task automatic idle();
    do_cycle(1'b1, 1'b0, 4'h0, 3'd0, 2'b00, 1'b0);
  endtask

  initial begin
    logic [3:0] r_src;
    logic [2:0] r_gate;
    logic [1:0] r_kind;
    for (int i = 0; i < 5; i++) begin m_owner[i] = 4'hF; m_last[i] = 0; end

    // Reset
    do_cycle(1'b0, 1'b0, 4'h0, 3'd0, 2'b00, 1'b0);
    do_cycle(1'b0, 1'b1, 4'h2, 3'd1, 2'b00, 1'b1);
    check("reset_owners", 32'({north_source, east_source, south_source, west_source, ip_source}), 32'hFFFFF);
    check("reset_busy", 32'(busy), 32'h0);
    idle();

    // Lock and release on the east gate
    do_cycle(1'b1, 1'b1, 4'h2, 3'd1, 2'b00, 1'b1);
    check("lock_east", 32'(east_source), 32'h2);
    check("lock_busy", 32'(busy), 32'b00010);
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b1, 4'h2, 3'd1, 2'b01, 1'b1);
    do_cycle(1'b1, 1'b1, 4'h2, 3'd1, 2'b10, 1'b1);
    check("release_east", 32'(east_source), 32'hF);
    check("release_noerr", 32'(err_pulse), 32'h0);

    // Conflict on the north gate, then the same claim stalled
    do_cycle(1'b1, 1'b1, 4'h3, 3'd0, 2'b00, 1'b1);
    do_cycle(1'b1, 1'b1, 4'h5, 3'd0, 2'b00, 1'b1);
    check("conflict_err", 32'(err_pulse), 32'h1);
    check("conflict_keep", 32'(north_source), 32'h3);
    do_cycle(1'b1, 1'b1, 4'h5, 3'd0, 2'b00, 1'b0);
    check("stall_noerr", 32'(err_pulse), 32'h0);
    do_cycle(1'b1, 1'b1, 4'h3, 3'd0, 2'b10, 1'b1);

    // Watchdog release exactly five edges after the head
    do_cycle(1'b1, 1'b1, 4'h1, 3'd4, 2'b00, 1'b1);
    for (int i = 0; i < 4; i++) idle();
    check("wd_hold", 32'(ip_source), 32'h1);
    idle();
    check("wd_release", 32'(ip_source), 32'hF);
    check("wd_pulse", 32'(timeout_pulse), 32'b10000);
    idle();
    check("wd_pulse_once", 32'(timeout_pulse), 32'h0);

    // Owner body in the expiry cycle keeps the gate
    do_cycle(1'b1, 1'b1, 4'h1, 3'd4, 2'b00, 1'b1);
    for (int i = 0; i < 4; i++) idle();
    do_cycle(1'b1, 1'b1, 4'h1, 3'd4, 2'b01, 1'b1);
    check("wd_body_keep", 32'(ip_source), 32'h1);
    check("wd_body_nopulse", 32'(timeout_pulse), 32'h0);
    // Foreign head in the expiry cycle: error and release, no re-acquire
    for (int i = 0; i < 4; i++) idle();
    do_cycle(1'b1, 1'b1, 4'h7, 3'd4, 2'b00, 1'b1);
    check("wd_foreign_free", 32'(ip_source), 32'hF);
    check("wd_foreign_err", 32'(err_pulse), 32'h1);

    // Illegal claims
    do_cycle(1'b1, 1'b1, 4'h1, 3'd6, 2'b00, 1'b1);
    check("ill_gate", 32'(err_pulse), 32'h1);
    do_cycle(1'b1, 1'b1, 4'hF, 3'd0, 2'b00, 1'b1);
    check("ill_src", 32'(err_pulse), 32'h1);
    do_cycle(1'b1, 1'b1, 4'h1, 3'd2, 2'b11, 1'b0);
    check("ill_kind", 32'(err_pulse), 32'h1);
    check("ill_busy", 32'(busy), 32'h0);

    // Reset mid-packet drops ownership silently
    do_cycle(1'b1, 1'b1, 4'h2, 3'd0, 2'b00, 1'b1);
    do_cycle(1'b1, 1'b1, 4'h3, 3'd2, 2'b00, 1'b1);
    check("pre_rst_busy", 32'(busy), 32'b00101);
    do_cycle(1'b0, 1'b1, 4'hF, 3'd7, 2'b11, 1'b1);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_pulses", 32'({timeout_pulse, err_pulse}), 32'h0);

    // Randomized traffic against the reference
    for (int n = 0; n < 800; n++) begin
      r_src  = ($urandom_range(0, 11) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      r_gate = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      r_kind = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      do_cycle(($urandom_range(0, 149) != 0), ($urandom_range(0, 9) < 6), r_src, r_gate,
               r_kind, ($urandom_range(0, 9) < 8));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
